// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes and the
// output-port allocator state encoding.
package noc_pkg;

  typedef enum logic [1:0] {
    FT_HEADTAIL = 2'b00,
    FT_HEAD     = 2'b01,
    FT_BODY     = 2'b10,
    FT_TAIL     = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin pick: first request found
// scanning upward from ptr+1, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = IW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: locks one input per
// packet, streams its flits, releases on tail or length cap.
module output_port_allocator
  import noc_pkg::*;
#(
  parameter int INPUTS        = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int TYPE_WIDTH    = 2,
  parameter int FlitPerPacket = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS-1:0]            req_bus,
  input  logic [INPUTS*DATA_WIDTH-1:0] data_in_bus,
  input  logic [INPUTS-1:0]            valid_in_bus,
  output logic [INPUTS-1:0]            ready_in_bus,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [$clog2(INPUTS)-1:0]    grant_idx,
  output logic                         locked,
  output logic                         len_error
);

  localparam int IW = $clog2(INPUTS);
  localparam int CW = $clog2(FlitPerPacket + 1);

  state_e                r_state;
  state_e                w_state_nx;
  logic [IW-1:0]         r_grant;
  logic [IW-1:0]         r_ptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_len_err;
  logic [INPUTS-1:0]     w_elig;
  logic [INPUTS-1:0]     w_arb_gnt;
  logic [IW-1:0]         w_arb_idx;
  logic                  w_arb_any;
  logic [TYPE_WIDTH-1:0] w_type;
  logic [TYPE_WIDTH-1:0] w_in_type;
  logic [CW-1:0]         w_cnt_nx;
  logic                  w_xfer;
  logic                  w_tail;
  logic                  w_full;
  logic                  w_release;

  always_comb begin
    w_elig    = '0;
    w_in_type = '0;
    for (int i = 0; i < INPUTS; i++) begin
      w_in_type = data_in_bus[i*DATA_WIDTH + DATA_WIDTH - 1 -: TYPE_WIDTH];
      w_elig[i] = req_bus[i] && valid_in_bus[i] &&
                  (w_in_type == TYPE_WIDTH'(FT_HEAD) ||
                   w_in_type == TYPE_WIDTH'(FT_HEADTAIL));
    end
  end

  rr_arbiter #(
    .N (INPUTS)
  ) u_arb (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_arb_any = |w_arb_gnt;

  assign w_type = data_in_bus[int'(r_grant)*DATA_WIDTH + DATA_WIDTH - 1 -: TYPE_WIDTH];
  assign w_tail = (w_type == TYPE_WIDTH'(FT_TAIL)) ||
                  (w_type == TYPE_WIDTH'(FT_HEADTAIL));
  assign w_xfer = (r_state == ST_LOCKED) &&
                  valid_in_bus[r_grant] && ready_out;
  assign w_cnt_nx  = r_cnt + CW'(1);
  assign w_full    = (w_cnt_nx == CW'(FlitPerPacket));
  assign w_release = w_xfer && (w_tail || w_full);

  always_comb begin
    w_state_nx   = r_state;
    data_out     = '0;
    valid_out    = 1'b0;
    ready_in_bus = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_any) w_state_nx = ST_LOCKED;
      end
      ST_LOCKED: begin
        data_out              = data_in_bus[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
        valid_out             = valid_in_bus[r_grant];
        ready_in_bus[r_grant] = ready_out;
        if (w_release) w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nx;
  end

  // Grant and count clear happen together so a new packet starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant   <= '0;
      r_ptr     <= IW'(INPUTS - 1);
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_xfer && w_full && !w_tail;
      if (r_state == ST_IDLE && w_arb_any) begin
        r_grant <= w_arb_idx;
        r_cnt   <= '0;
      end else if (w_xfer) begin
        r_cnt <= w_cnt_nx;
      end
      if (w_release) r_ptr <= r_grant;
    end
  end

  assign grant_idx = r_grant;
  assign locked    = (r_state == ST_LOCKED);
  assign len_error = r_len_err;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator with
// hand-computed expectations and immediate assertions.
module tb_output_port_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_bus;
  logic [95:0] data_in_bus;
  logic [2:0]  valid_in_bus;
  logic [2:0]  ready_in_bus;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_out;
  logic [1:0]  grant_idx;
  logic        locked;
  logic        len_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  output_port_allocator #(
    .INPUTS        (3),
    .DATA_WIDTH    (32),
    .TYPE_WIDTH    (2),
    .FlitPerPacket (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_bus      (req_bus),
    .data_in_bus  (data_in_bus),
    .valid_in_bus (valid_in_bus),
    .ready_in_bus (ready_in_bus),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .grant_idx    (grant_idx),
    .locked       (locked),
    .len_error    (len_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [31:0] v);
    data_in_bus[i*32 +: 32] = v;
  endtask

  initial begin
    int          exp_g [4];
    logic [31:0] pk4 [4];
    logic [31:0] pk5 [4];
    logic [31:0] ev;
    exp_g = '{0, 1, 2, 0};
    pk4   = '{32'h4000_0021, 32'h8000_0022, 32'h8000_0023, 32'hC000_0024};
    pk5   = '{32'h8000_0052, 32'h8000_0054, 32'h8000_0055, 32'hC000_0056};

    rst = 1'b0; req_bus = '0; valid_in_bus = '0;
    data_in_bus = '0; ready_out = 1'b1;
    #12;
    chk("rst_locked", locked, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ready", ready_in_bus, 0);
    chk("rst_lenerr", len_error, 0);
    rst = 1'b1;
    tick();

    // all three inputs keep offering single-flit packets
    put(0, 32'h10); put(1, 32'h20); put(2, 32'h30);
    req_bus = 3'b111; valid_in_bus = 3'b111;
    #2;
    chk("rr_idle_valid", valid_out, 0);
    chk("rr_idle_ready", ready_in_bus, 0);
    tick();
    for (int g = 0; g < 4; g++) begin
      #2;
      chk("rr_locked", locked, 1);
      chk("rr_grant", grant_idx, exp_g[g]);
      chk("rr_data", data_out, (exp_g[g] + 1) * 16);
      chk("rr_ready", ready_in_bus, 32'(1 << exp_g[g]));
      tick();
      #2;
      chk("rr_gap_locked", locked, 0);
      chk("rr_gap_valid", valid_out, 0);
      if (g == 3) begin
        req_bus = '0; valid_in_bus = '0;
      end
      tick();
    end

    // single HEADTAIL on input 1
    put(1, 32'hA5); req_bus = 3'b010; valid_in_bus = 3'b010;
    #2;
    chk("ht_pre_valid", valid_out, 0);
    chk("ht_pre_data", data_out, 0);
    tick();
    #2;
    chk("ht_locked", locked, 1);
    chk("ht_grant", grant_idx, 1);
    chk("ht_data", data_out, 32'hA5);
    chk("ht_valid", valid_out, 1);
    tick();
    req_bus = '0; valid_in_bus = '0;
    #2;
    chk("ht_post_locked", locked, 0);
    chk("ht_post_lenerr", len_error, 0);
    tick();

    // 4-flit packet on input 2 while input 0 also waits
    put(0, 32'h11); put(2, pk4[0]);
    req_bus = 3'b101; valid_in_bus = 3'b101;
    tick();
    for (int f = 0; f < 4; f++) begin
      #2;
      chk("pk4_locked", locked, 1);
      chk("pk4_grant", grant_idx, 2);
      chk("pk4_data", data_out, pk4[f]);
      chk("pk4_ready", ready_in_bus, 3'b100);
      tick();
      if (f < 3) put(2, pk4[f + 1]);
    end
    req_bus = 3'b001; valid_in_bus = 3'b001;
    #2;
    chk("pk4_gap_locked", locked, 0);
    chk("pk4_gap_valid", valid_out, 0);
    tick();
    #2;
    chk("pk4_next_grant", grant_idx, 0);
    chk("pk4_next_data", data_out, 32'h11);
    tick();
    req_bus = '0; valid_in_bus = '0;
    #2;
    chk("pk4_end_locked", locked, 0);
    tick();

    // stall for 3 cycles on the second flit of a 5-flit packet
    put(0, 32'h4000_0051); req_bus = 3'b001; valid_in_bus = 3'b001;
    tick();
    #2;
    chk("st_head", data_out, 32'h4000_0051);
    tick();
    put(0, pk5[0]); ready_out = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #2;
      chk("st_data", data_out, pk5[0]);
      chk("st_valid", valid_out, 1);
      chk("st_ready", ready_in_bus, 0);
      chk("st_locked", locked, 1);
      tick();
    end
    ready_out = 1'b1;
    for (int f = 0; f < 4; f++) begin
      #2;
      chk("st_flit", data_out, pk5[f]);
      chk("st_flit_locked", locked, 1);
      chk("st_flit_lenerr", len_error, 0);
      chk("st_flit_ready", ready_in_bus, 3'b001);
      tick();
      if (f < 3) put(0, pk5[f + 1]);
    end
    req_bus = '0; valid_in_bus = '0;
    #2;
    chk("st_end_locked", locked, 0);
    chk("st_end_lenerr", len_error, 0);
    tick();

    // HEAD + 5 BODY on input 1: forced release after 6 transfers
    ev = 32'h4000_0061;
    put(1, ev); req_bus = 3'b010; valid_in_bus = 3'b010;
    tick();
    for (int k = 0; k < 6; k++) begin
      #2;
      chk("len_locked", locked, 1);
      chk("len_grant", grant_idx, 1);
      chk("len_data", data_out, ev);
      chk("len_noerr", len_error, 0);
      tick();
      ev = 32'h8000_0062 + 32'(k);
      put(1, ev);
    end
    #2;
    chk("len_rel_locked", locked, 0);
    chk("len_pulse", len_error, 1);
    tick();
    #2;
    chk("len_pulse_end", len_error, 0);
    chk("len_body_ignored", locked, 0);
    tick();
    #2;
    chk("len_body_ignored2", locked, 0);
    req_bus = '0; valid_in_bus = '0;
    tick();

    // reset during the second flit of an input-2 packet
    put(0, 32'h81); put(2, 32'h4000_0091);
    req_bus = 3'b101; valid_in_bus = 3'b101;
    tick();
    #2;
    chk("rm_grant", grant_idx, 2);
    tick();
    put(2, 32'h8000_0092);
    #2;
    chk("rm_second", data_out, 32'h8000_0092);
    rst = 1'b0;
    #1;
    chk("rm_locked", locked, 0);
    chk("rm_valid", valid_out, 0);
    chk("rm_data", data_out, 0);
    chk("rm_ready", ready_in_bus, 0);
    chk("rm_grant0", grant_idx, 0);
    #2;
    rst = 1'b1;
    put(2, 32'h4000_0093);
    tick();
    #2;
    chk("rm_after_locked", locked, 1);
    chk("rm_after_grant", grant_idx, 0);
    chk("rm_after_data", data_out, 32'h81);
    tick();
    req_bus = '0; valid_in_bus = '0;
    #2;
    chk("rm_end_locked", locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/output_port_allocator.md
OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 Parameter INPUTS, default 3: number of router input ports competing for this output port; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 32: flit width in bits.
REQ-003 Parameter TYPE_WIDTH, default 2: flit-type field width, located at data[DATA_WIDTH-1 -: TYPE_WIDTH].
REQ-004 Parameter FlitPerPacket, default 6: maximum number of flits in one packet.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port req_bus, input, INPUTS: bit i set means route computation steers input i to this output.
REQ-008 Port data_in_bus, input, INPUTS*DATA_WIDTH: flits from the input FIFOs; input i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port valid_in_bus, input, INPUTS: per-input flit valid.
REQ-010 Port ready_in_bus, output, INPUTS: per-input acceptance.
REQ-011 Port data_out, output, DATA_WIDTH: flit toward the output link.
REQ-012 Port valid_out, output, 1: output flit valid.
REQ-013 Port ready_out, input, 1: downstream ready.
REQ-014 Port grant_idx, output, $clog2(INPUTS): index of the currently locked input.
REQ-015 Port locked, output, 1: high while a packet holds the port.
REQ-016 Port len_error, output, 1: one-cycle pulse when a packet is force-released.

Function
REQ-017 Flit types: 00 HEADTAIL, 01 HEAD, 10 BODY, 11 TAIL.
REQ-018 A transfer is valid_out && ready_out in the same cycle.
REQ-019 FSM has two states, IDLE and LOCKED.
REQ-020 In IDLE, input i is eligible only when req_bus[i], valid_in_bus[i] and the input's type is HEAD or HEADTAIL are all true; non-head flits are ignored.
REQ-021 In IDLE, if any input is eligible, the block grants the first eligible input searching round-robin from ptr+1 (mod INPUTS), registers it into grant_idx, and moves to LOCKED on the next edge.
REQ-022 In IDLE, valid_out is 0, data_out is 0 and ready_in_bus is all-zero.
REQ-023 In LOCKED, data_out, valid_out and ready_in_bus are combinational: data_out = slice[g], valid_out = valid_in_bus[g], ready_in_bus[g] = ready_out, all other ready bits 0 (g = grant_idx).
REQ-024 Latency: a head flit presented in cycle N with the port IDLE appears on data_out in cycle N+1.
REQ-025 A flit counter counts transfers in LOCKED; it is cleared on entry to LOCKED.
REQ-026 A transfer of a TAIL or HEADTAIL flit returns the FSM to IDLE and sets ptr = g.
REQ-027 A transfer that brings the counter to FlitPerPacket releases the port, sets ptr = g and returns to IDLE; if that flit is not TAIL/HEADTAIL, len_error pulses for one cycle.
REQ-028 req_bus is not examined in LOCKED; the lock persists until release regardless of req_bus changes.
REQ-029 There is one mandatory idle cycle between consecutive packets; the release and the next grant never occur in the same cycle.
REQ-030 ready_out low in LOCKED stalls the port: the counter and FSM hold and valid_out mirrors the input.

Reset
REQ-031 Asserting rst (low) asynchronously forces state IDLE, grant_idx 0, locked 0, len_error 0, counter 0 and ptr = INPUTS-1, so input 0 has first priority.
REQ-032 Reset mid-packet abandons the packet; after deassertion the block behaves as from power-up.

Structure
REQ-033 The flit-type constants and the state encoding are defined in the shared package noc_pkg.
REQ-034 The round-robin priority selection is a combinational sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant and index).

Verification
REQ-035 Single HEADTAIL flit 0xA5 on input 1 -> data_out = 0xA5 one cycle later; locked drops after the transfer.
REQ-036 HEAD/BODY/BODY/TAIL on input 2 while input 0 also requests -> input 2 keeps all 4 flits uninterrupted if granted first; input 0 is granted after the idle cycle.
REQ-037 Inputs 0, 1 and 2 continuously requesting single-flit packets -> grants go 0, 1, 2, 0, each separated by one idle cycle.
REQ-038 Six HEAD/BODY flits with no TAIL, FlitPerPacket = 6 -> release after the sixth transfer; len_error is high for exactly 1 cycle.
REQ-039 ready_out held low for 3 cycles mid-packet -> data_out stable, counter frozen, no flit loss or duplication.
REQ-040 rst asserted in the middle of the second flit -> outputs go to 0 immediately; the next grant goes to input 0.
